// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI mode-0 (CPOL=0, CPHA=0) responder, oversampled in the clk domain.
// Nothing is clocked by SCLK; all SPI pins are synchronised and edge-detected.
// Ports:
//   clk, rst_n           system clock (>= 4x SCLK), asynchronous active-low reset
//   spi_sclk/cs_n/mosi   SPI inputs from the initiator
//   spi_miso             SPI output, 0 while deselected
//   tx_data/valid/ready  one-entry holding register for the next word to send
//   rx_data/valid        last received word and its 1-cycle update pulse
//   busy                 1 while selected
module spi_slave_if #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_hist_q, sclk_hist_d;
  logic                   cs_hist_q, cs_hist_d;
  state_e                 state_q, state_d;
  logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      shift_tx_q, shift_tx_d;
  logic [DATA_W-1:0]      shift_rx_q, shift_rx_d;
  logic [DATA_W-1:0]      hold_q, hold_d;
  logic                   full_q, full_d;
  logic                   reload_q, reload_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;

  logic            sclk_s, cs_s, mosi_s;
  logic            sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic            tx_wr;
  logic [CntW-1:0] cnt_inc;
  logic [DATA_W-1:0] rx_next;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign sclk_fall = ~sclk_s & sclk_hist_q;
  assign cs_rise   = cs_s & ~cs_hist_q;
  assign cs_fall   = ~cs_s & cs_hist_q;
  assign tx_wr     = tx_valid & ~full_q;
  assign cnt_inc   = bit_cnt_q + 1'b1;
  assign rx_next   = {shift_rx_q[DATA_W-2:0], mosi_s};

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_hist_d = sclk_s;
    cs_hist_d   = cs_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_tx_d  = shift_tx_q;
    shift_rx_d  = shift_rx_q;
    hold_d      = hold_q;
    full_d      = full_q;
    reload_d    = reload_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;

    // A write can only land when empty, so it never collides with a load taking the entry.
    if (tx_wr) begin
      hold_d = tx_data;
      full_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (cs_fall) state_d = StLoad;
      end
      StLoad: begin
        if (cs_rise) begin
          state_d = StIdle;
        end else begin
          // Load uses pre-write state: empty holding sends an all-zero underrun word.
          shift_tx_d = full_q ? hold_q : '0;
          if (full_q) full_d = 1'b0;
          shift_rx_d = '0;
          bit_cnt_d  = '0;
          reload_d   = 1'b0;
          state_d    = StShift;
        end
      end
      StShift: begin
        if (cs_rise) begin
          // Deselect drops the partial word and the consumed tx word.
          state_d   = StIdle;
          bit_cnt_d = '0;
          reload_d  = 1'b0;
        end else if (sclk_rise) begin
          shift_rx_d = rx_next;
          if (cnt_inc == CntW'(DATA_W)) begin
            rx_data_d  = rx_next;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            reload_d   = 1'b1;
          end else begin
            bit_cnt_d = cnt_inc;
          end
        end else if (sclk_fall) begin
          if (reload_q) begin
            shift_tx_d = full_q ? hold_q : '0;
            if (full_q) full_d = 1'b0;
            reload_d = 1'b0;
          end else begin
            shift_tx_d = {shift_tx_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b0;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_tx_q  <= '0;
      shift_rx_q  <= '0;
      hold_q      <= '0;
      full_q      <= 1'b0;
      reload_q    <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_hist_q <= sclk_hist_d;
      cs_hist_q   <= cs_hist_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_tx_q  <= shift_tx_d;
      shift_rx_q  <= shift_rx_d;
      hold_q      <= hold_d;
      full_q      <= full_d;
      reload_q    <= reload_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
    end
  end

  assign spi_miso = (state_q == StShift) & shift_tx_q[DATA_W-1];
  assign busy     = (state_q != StIdle);
  assign tx_ready = ~full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule
